// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer:
// the FSM state encoding and the packed control word the sequencer drives.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_e;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MEM_TIMEOUT_DEF = 64;
    localparam int         CNT_W_DEF       = 16;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_flush;
        logic id_flush;
        logic ex_flush;
        logic mem_wb_flush;
        logic pc_src;
    } hz_ctl_t;

    // Canned control words, field order as in hz_ctl_t
    localparam hz_ctl_t CTL_IDLE   = 9'b0000_0000_0;
    localparam hz_ctl_t CTL_RUN    = 9'b1111_0000_0;
    localparam hz_ctl_t CTL_FREEZE = 9'b0000_0001_0;
    localparam hz_ctl_t CTL_REDIR  = 9'b1111_1110_1;
    localparam hz_ctl_t CTL_LU     = 9'b0011_0100_0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Asynchronous active-low reset, synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory waits,
// MEM-stage redirects and load-use hazards into register enables and flushes.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_Jump,
    input  logic             EX_MEM_ALU_zero,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             PCSrc,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state_q, state_d;
    logic              run_en_q, run_en_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    hz_ctl_t           ctl;

    logic mem_wait, redirect, load_use, wait_done;

    assign mem_wait  = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
    assign redirect  = EX_MEM_Jump | (EX_MEM_Branch & EX_MEM_ALU_zero);
    assign load_use  = ID_EX_MemRead & (ID_EX_RegisterRt != REG_ZERO) &
                       ((ID_EX_RegisterRt == IF_ID_RegisterRs) |
                        (ID_EX_RegisterRt == IF_ID_RegisterRt));
    assign wait_done = mem_ready | (wait_cnt_q == WAIT_LIMIT);

    // run_en delays release by one edge so the pipeline never starts in the reset cycle
    assign run_en_d = 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            run_en_q    <= 1'b0;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_en_q    <= run_en_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        if (run_en_q) begin
            unique case (state_q)
                RUN, LU_STALL: begin
                    if (mem_wait) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else if (redirect) begin
                        state_d = FLUSH;
                    end else if (load_use && (state_q == RUN)) begin
                        state_d = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: state_d = RUN;
                MEM_WAIT: begin
                    if (wait_done) begin
                        wait_cnt_d = '0;
                        state_d    = redirect ? FLUSH : RUN;
                        if (!mem_ready) begin
                            mem_error_d = 1'b1;
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ctl = CTL_IDLE;
        if (run_en_q) begin
            ctl = CTL_RUN;
            unique case (state_q)
                RUN, LU_STALL: begin
                    if (mem_wait) begin
                        ctl = CTL_FREEZE;
                    end else if (redirect) begin
                        ctl = CTL_REDIR;
                    end else if (load_use && (state_q == RUN)) begin
                        ctl = CTL_LU;
                    end
                end
                FLUSH: ctl = CTL_RUN;
                MEM_WAIT: begin
                    if (!wait_done) begin
                        ctl = CTL_FREEZE;
                    end else if (redirect) begin
                        ctl = CTL_REDIR;
                    end
                end
                default: ctl = CTL_RUN;
            endcase
        end
    end

    assign PC_Write     = ctl.pc_write;
    assign IF_ID_Write  = ctl.if_id_write;
    assign ID_EX_Write  = ctl.id_ex_write;
    assign EX_MEM_Write = ctl.ex_mem_write;
    assign IF_Flush     = ctl.if_flush;
    assign ID_Flush     = ctl.id_flush;
    assign EX_Flush     = ctl.ex_flush;
    assign MEM_WB_Flush = ctl.mem_wb_flush;
    assign PCSrc        = ctl.pc_src;
    assign mem_error    = mem_error_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_en_q & ~ctl.pc_write),
        .clear (1'b0),
        .count (stall_cycles)
    );

    // pc_src is only ever asserted on a redirect, and only while running
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctl.pc_src),
        .clear (1'b0),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs driven at the falling edge,
// Mealy outputs and statistics checked 1ns later.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [8:0] C_IDLE   = 9'b0000_0000_0;
    localparam logic [8:0] C_RUN    = 9'b1111_0000_0;
    localparam logic [8:0] C_FREEZE = 9'b0000_0001_0;
    localparam logic [8:0] C_REDIR  = 9'b1111_1110_1;
    localparam logic [8:0] C_LU     = 9'b0011_0100_0;

    logic clk = 1'b0;
    logic rst;
    logic ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic EX_MEM_Branch, EX_MEM_Jump, EX_MEM_ALU_zero;
    logic EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready;
    logic PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
    logic IF_Flush, ID_Flush, EX_Flush, MEM_WB_Flush, PCSrc, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [8:0] ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .EX_MEM_Branch    (EX_MEM_Branch),
        .EX_MEM_Jump      (EX_MEM_Jump),
        .EX_MEM_ALU_zero  (EX_MEM_ALU_zero),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .mem_ready        (mem_ready),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .ID_EX_Write      (ID_EX_Write),
        .EX_MEM_Write     (EX_MEM_Write),
        .IF_Flush         (IF_Flush),
        .ID_Flush         (ID_Flush),
        .EX_Flush         (EX_Flush),
        .MEM_WB_Flush     (MEM_WB_Flush),
        .PCSrc            (PCSrc),
        .mem_error        (mem_error),
        .stall_cycles     (stall_cycles),
        .flush_events     (flush_events)
    );

    assign ctl = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                  IF_Flush, ID_Flush, EX_Flush, MEM_WB_Flush, PCSrc};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        EX_MEM_Branch = 0; EX_MEM_Jump = 0; EX_MEM_ALU_zero = 0;
        EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; mem_ready = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle_check(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'(ctl), 32'(exp));
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        next_cycle();                          // t=10
        next_cycle();                          // t=20
        rst = 1;
        settle_check("release_hold", C_IDLE);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_flush", 32'(flush_events), 0);
        chk("rst_memerr", 32'(mem_error), 0);

        next_cycle();
        settle_check("run_default", C_RUN);

        // Load-use on Rs held two cycles: exactly one stall
        next_cycle();
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
        settle_check("lu_rs_c1", C_LU);
        next_cycle();
        settle_check("lu_rs_c2", C_RUN);
        next_cycle();
        clear_inputs();
        settle_check("lu_rs_after", C_RUN);
        chk("lu_stall_cnt", 32'(stall_cycles), 1);

        // Destination r0 never stalls
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0;
        next_cycle();
        settle_check("lu_r0_c1", C_RUN);
        next_cycle();
        settle_check("lu_r0_c2", C_RUN);

        // Match on the Rt source
        next_cycle();
        ID_EX_RegisterRt = 7; IF_ID_RegisterRs = 3; IF_ID_RegisterRt = 7;
        settle_check("lu_rt", C_LU);
        next_cycle();
        clear_inputs();
        settle_check("lu_rt_after", C_RUN);
        chk("lu_rt_stall_cnt", 32'(stall_cycles), 2);

        // Taken branch with coincident load-use: redirect wins, FLUSH suppresses load-use
        next_cycle();
        EX_MEM_Branch = 1; EX_MEM_ALU_zero = 1;
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5;
        settle_check("br_lu_redir", C_REDIR);
        next_cycle();
        EX_MEM_Branch = 0; EX_MEM_ALU_zero = 0;
        settle_check("flush_no_lu", C_RUN);
        next_cycle();
        clear_inputs();
        settle_check("br_after", C_RUN);
        chk("br_flush_cnt", 32'(flush_events), 1);
        chk("br_stall_cnt", 32'(stall_cycles), 2);

        // Untaken branch, then a jump
        EX_MEM_Branch = 1; EX_MEM_ALU_zero = 0;
        settle_check("br_untaken", C_RUN);
        next_cycle();
        EX_MEM_Branch = 0; EX_MEM_Jump = 1;
        settle_check("jump_redir", C_REDIR);
        next_cycle();
        clear_inputs();
        settle_check("jump_flush_state", C_RUN);
        chk("jump_flush_cnt", 32'(flush_events), 2);

        // Memory wait: three frozen cycles, release on the fourth
        next_cycle();
        EX_MEM_MemRead = 1; mem_ready = 0;
        settle_check("mw_c1", C_FREEZE);
        next_cycle();
        settle_check("mw_c2", C_FREEZE);
        next_cycle();
        settle_check("mw_c3", C_FREEZE);
        next_cycle();
        mem_ready = 1;
        settle_check("mw_release", C_RUN);
        next_cycle();
        clear_inputs();
        settle_check("mw_after", C_RUN);
        chk("mw_stall_cnt", 32'(stall_cycles), 5);
        chk("mw_no_err", 32'(mem_error), 0);

        // Timeout: four frozen cycles, forced release, sticky error
        next_cycle();
        EX_MEM_MemWrite = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle_check($sformatf("to_frz%0d", i), C_FREEZE);
            next_cycle();
        end
        settle_check("to_release", C_RUN);
        next_cycle();
        clear_inputs();
        settle_check("to_after", C_RUN);
        chk("to_memerr", 32'(mem_error), 1);
        chk("to_stall_cnt", 32'(stall_cycles), 9);

        // Second wait interrupted by reset
        next_cycle();
        EX_MEM_MemRead = 1; mem_ready = 0;
        settle_check("rw_c1", C_FREEZE);
        next_cycle();
        settle_check("rw_c2", C_FREEZE);
        rst = 0;
        settle_check("rw_reset_ctl", C_IDLE);
        chk("rw_reset_memerr", 32'(mem_error), 0);
        chk("rw_reset_stall", 32'(stall_cycles), 0);
        chk("rw_reset_flush", 32'(flush_events), 0);
        next_cycle();
        rst = 1;
        settle_check("rw_rel_hold", C_IDLE);

        // Saturation: held wait yields well over 2^CNT_W+3 stall cycles
        for (int i = 0; i < 30; i++) begin
            next_cycle();
        end
        #1;
        chk("sat_stall", 32'(stall_cycles), 32'hF);
        chk("sat_flush", 32'(flush_events), 0);

        clear_inputs();
        next_cycle();
        next_cycle();
        settle_check("final_run", C_RUN);
        chk("sat_hold", 32'(stall_cycles), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors %0d", errors);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the write-enables and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Handles three events: load-use hazards, taken branch/jump resolved in MEM, and multi-cycle data-memory waits.
- Also keeps saturating stall/flush statistics and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before a timeout.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset. Asserted = 0.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  5  load destination register.
- IF_ID_RegisterRs  in  5  source register of the instruction in ID.
- IF_ID_RegisterRt  in  5  source register of the instruction in ID.
- EX_MEM_Branch, EX_MEM_Jump, EX_MEM_ALU_zero  in  1 each  control for the instruction in MEM.
- EX_MEM_MemRead, EX_MEM_MemWrite  in  1 each  memory op in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  register enables.
- IF_Flush, ID_Flush, EX_Flush, MEM_WB_Flush  out  1 each  synchronous bubble insertion into IF_ID/ID_EX/EX_MEM/MEM_WB.
- PCSrc  out  1  select branch/jump target.
- mem_error  out  1  sticky timeout flag.
- stall_cycles, flush_events  out  CNT_W each  saturating statistics.

Behaviour:
- States: RUN, LU_STALL, FLUSH, MEM_WAIT. State is registered; outputs are Mealy (combinational from state and inputs).
- Reset (rst=0, async):
  - state=RUN, run_en=0, wait_cnt=0, counters=0, mem_error=0.
  - While run_en=0, all enables, flushes and PCSrc are 0.
  - run_en sets on the first rising clk edge after rst rises. Zero-latency release is not allowed.
- Default (RUN, no event): all *_Write=1, all flushes=0, PCSrc=0.
- Event priority, evaluated in RUN: mem_wait > redirect > load_use.
- mem_wait = (EX_MEM_MemRead|EX_MEM_MemWrite) & ~mem_ready.
  - Action: all *_Write=0 and MEM_WB_Flush=1. Next state MEM_WAIT, wait_cnt=1.
- MEM_WAIT:
  - Same freeze outputs each cycle; wait_cnt increments.
  - On mem_ready=1: release that cycle (default outputs, or redirect if the MEM op is also a branch/jump, which cannot occur in this ISA). Return to RUN, clear wait_cnt.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready=0: set mem_error, force release as for mem_ready, return to RUN.
- redirect = EX_MEM_Jump | (EX_MEM_Branch & EX_MEM_ALU_zero).
  - Action: PCSrc=1, IF_Flush=ID_Flush=EX_Flush=1, enables=1. Next state FLUSH.
- FLUSH: lasts exactly one cycle.
  - Default outputs; load_use detection is suppressed.
  - redirect is ignored because EX_MEM now holds a bubble.
  - Returns to RUN.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRt!=0) & (ID_EX_RegisterRt==IF_ID_RegisterRs | ID_EX_RegisterRt==IF_ID_RegisterRt).
  - Action: PC_Write=0, IF_ID_Write=0, ID_Flush=1. Next state LU_STALL.
- LU_STALL: lasts exactly one cycle.
  - load_use is not re-evaluated, so there is no double stall.
  - mem_wait and redirect are still honoured with the same priority.
  - Returns to RUN or the event's state.
- Simultaneous redirect + load_use: redirect wins; the stall is dropped because the instruction in ID is flushed.
- Statistics:
  - stall_cycles +1 per cycle with PC_Write=0 while run_en=1.
  - flush_events +1 per redirect.
  - Both saturate at all-ones with no wrap.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: immediate return to reset values. mem_error clears only on reset.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN=2'd0, LU_STALL=2'd1, FLUSH=2'd2, MEM_WAIT=2'd3);
  - REG_ZERO=5'd0;
  - default MEM_TIMEOUT.
- One natural sub-module: sat_counter (CNT_W, inc, clear → count), instantiated twice.

Test Plan:
- Release rst at t=20ns → all outputs 0 until the next posedge, then PC_Write=IF_ID_Write=ID_EX_Write=EX_MEM_Write=1 and flushes 0.
- ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 for 2 cycles → exactly one cycle of PC_Write=0, IF_ID_Write=0, ID_Flush=1; stall_cycles=1. Repeat with Rt=0 → no stall.
- EX_MEM_Branch=1, EX_MEM_ALU_zero=1 with a coincident load-use → PCSrc=1, IF/ID/EX_Flush=1 for one cycle, no stall; flush_events=1.
- EX_MEM_MemRead=1, mem_ready low for 3 cycles then high → 3 frozen cycles with MEM_WB_Flush=1, release on the 4th; stall_cycles=3.
- MEM_TIMEOUT=4, mem_ready held 0 → mem_error=1 after 4 frozen cycles, pipeline resumes. Pulse rst low mid-wait on a second run → immediate reset values.
- Force 2^CNT_W+3 stall cycles (CNT_W=4 build) → stall_cycles holds 4'hF.
